sd_card_responder: RTL and testbench

SPI-mode SD card emulator: the target end of the sector-read protocol used by the console's SD card pager. It answers CMD0 (GO_IDLE), CMD1 (SEND_OP_COND) and CMD17 (READ_SINGLE_BLOCK). CMD17 data is streamed from a synchronous byte memory. It sits in simulation benches and in on-board loopback builds in place of a physical card, and the host master connects to it unmodified.

---
 rtl/sd_card_responder.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_sd_card_responder.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/sd_card_responder.sv
// sd_card_responder
//   SPI-mode (mode 0) SD card target. It answers CMD0, CMD1 and CMD17.
//   CMD17 streams one 512-byte sector from a synchronous byte memory.
//   It stands in for a physical card in benches and loopback builds.
//
// Ports
//   clk, reset       system clock; synchronous active-high reset
//   spi_cs           host chip select, active low
//   spi_clk          host SCLK, mode 0 (sample rising, shift falling)
//   spi_di           MOSI
//   spi_do           MISO
//   mem_address      byte address into the sector memory
//   mem_data         memory read data, valid 1 clk after mem_address
//   initialized      high once CMD1 has answered 0x00
//   sector_count     number of CMD17 blocks fully sent (wraps)
module sd_card_responder #(
  parameter int INIT_POLLS = 2,
  parameter int DATA_GAP   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_cs,
  input  logic        spi_clk,
  input  logic        spi_di,
  output logic        spi_do,
  output logic [23:0] mem_address,
  input  logic [7:0]  mem_data,
  output logic        initialized,
  output logic [7:0]  sector_count
);

  typedef enum logic [2:0] {
    RX_CMD, NCR, R1, GAP, TOKEN, DATA, CRC1, CRC2
  } tx_state_t;

  typedef struct packed {
    logic [5:0]  idx;
    logic [31:0] arg;
  } cmd_frame_t;

  // ---------------------------------------------------------------
  // Pin synchronizers and SCLK edge detect
  // ---------------------------------------------------------------
  logic [1:0] cs_sync, sclk_sync, di_sync;
  logic       sclk_q;
  logic       cs_s, sclk_s, di_s;
  logic       sclk_rise, sclk_fall;

  always_ff @(posedge clk) begin
    if (reset) begin
      cs_sync   <= 2'b11;
      sclk_sync <= 2'b00;
      di_sync   <= 2'b11;
      sclk_q    <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[0], spi_cs};
      sclk_sync <= {sclk_sync[0], spi_clk};
      di_sync   <= {di_sync[0], spi_di};
      sclk_q    <= sclk_sync[1];
    end
  end

  assign cs_s   = cs_sync[1];
  assign sclk_s = sclk_sync[1];
  assign di_s   = di_sync[1];

  // Edges only count while selected, so a byte that completes on the
  // same clk that CS rises is dropped.
  assign sclk_rise = ~cs_s &  sclk_s & ~sclk_q;
  assign sclk_fall = ~cs_s & ~sclk_s &  sclk_q;

  // ---------------------------------------------------------------
  // Bit level rx/tx
  // ---------------------------------------------------------------
  tx_state_t  state, state_nxt;
  logic [2:0] bit_count;
  logic [7:0] rx_shift, rx_byte;
  logic [7:0] tx_shift, tx_load;
  logic       byte_done;

  assign rx_byte   = {rx_shift[6:0], di_s};
  assign byte_done = sclk_rise & (bit_count == 3'd7);

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_count <= 3'd0;
      rx_shift  <= 8'h00;
      tx_shift  <= 8'hff;
      spi_do    <= 1'b1;
    end else if (cs_s) begin
      bit_count <= 3'd0;
      tx_shift  <= 8'hff;
      spi_do    <= 1'b1;
    end else begin
      if (sclk_rise) begin
        rx_shift  <= rx_byte;
        bit_count <= bit_count + 3'd1;
      end
      // The next byte's MSB goes out at once. The falling edge that
      // follows re-presents the same bit, because tx_shift still holds it
      // in bit 7. It shifts only after that.
      if (byte_done) begin
        tx_shift <= tx_load;
        spi_do   <= tx_load[7];
      end else if (sclk_fall) begin
        spi_do   <= tx_shift[7];
        tx_shift <= {tx_shift[6:0], 1'b1};
      end
    end
  end

  // ---------------------------------------------------------------
  // Command frame capture (only while idle in RX_CMD)
  // ---------------------------------------------------------------
  logic [2:0] frame_cnt;
  cmd_frame_t frame;
  logic       frame_done;

  assign frame_done = byte_done & (state == RX_CMD) & (frame_cnt == 3'd5);

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= 3'd0;
      frame     <= '0;
    end else if (cs_s) begin
      frame_cnt <= 3'd0;
    end else if (byte_done && state == RX_CMD) begin
      if (frame_cnt == 3'd0) begin
        if (rx_byte[7:6] == 2'b01) begin
          frame.idx <= rx_byte[5:0];
          frame_cnt <= 3'd1;
        end
      end else if (frame_cnt == 3'd5) begin
        frame_cnt <= 3'd0;             // CRC byte, not checked
      end else begin
        frame.arg <= {frame.arg[23:0], rx_byte};
        frame_cnt <= frame_cnt + 3'd1;
      end
    end
  end

  // ---------------------------------------------------------------
  // Card state and R1 decision (taken when the CRC byte lands)
  // ---------------------------------------------------------------
  logic       in_idle;
  logic [7:0] polls;
  logic [7:0] r1_new, r1_q;
  logic       data_new, data_q;
  logic [23:0] base_q;

  always_comb begin
    r1_new   = {7'b0000010, in_idle};
    data_new = 1'b0;
    case (frame.idx)
      6'd0:  r1_new = 8'h01;
      6'd1:  r1_new = (polls != 8'd0) ? 8'h01 : 8'h00;
      6'd17: begin
        r1_new   = initialized ? 8'h00 : 8'h05;
        data_new = initialized;
      end
      default: ;
    endcase
  end

  // Not cleared by CS: the card stays initialized across deselects.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_idle     <= 1'b1;
      initialized <= 1'b0;
      polls       <= 8'(INIT_POLLS);
      r1_q        <= 8'hff;
      data_q      <= 1'b0;
      base_q      <= 24'd0;
    end else if (frame_done) begin
      r1_q   <= r1_new;
      data_q <= data_new;
      base_q <= {frame.arg[23:9], 9'd0};
      case (frame.idx)
        6'd0: begin
          in_idle     <= 1'b1;
          initialized <= 1'b0;
          polls       <= 8'(INIT_POLLS);
        end
        6'd1: begin
          if (polls != 8'd0) begin
            polls <= polls - 8'd1;
          end else begin
            in_idle     <= 1'b0;
            initialized <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------
  // Tx byte sequencer. The state names the byte currently on MISO.
  // On each byte completion, pick the next byte and state.
  // ---------------------------------------------------------------
  logic [7:0] gap_cnt;
  logic [8:0] byte_idx;
  logic       mem_set, mem_inc, sec_inc;

  always_ff @(posedge clk) begin
    if (reset || cs_s) state <= RX_CMD;
    else if (byte_done) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tx_load   = 8'hff;
    mem_set   = 1'b0;
    mem_inc   = 1'b0;
    sec_inc   = 1'b0;
    if (byte_done) begin
      case (state)
        RX_CMD: if (frame_done) state_nxt = NCR;
        NCR: begin
          state_nxt = R1;
          tx_load   = r1_q;
        end
        R1: begin
          if (!data_q) begin
            state_nxt = RX_CMD;
          end else if (DATA_GAP > 0) begin
            state_nxt = GAP;
          end else begin
            state_nxt = TOKEN;
            tx_load   = 8'hfe;
            mem_set   = 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == 8'(DATA_GAP - 1)) begin
            state_nxt = TOKEN;
            tx_load   = 8'hfe;
            mem_set   = 1'b1;
          end
        end
        TOKEN: begin
          state_nxt = DATA;
          tx_load   = mem_data;
          mem_inc   = 1'b1;
        end
        DATA: begin
          if (byte_idx == 9'd511) begin
            state_nxt = CRC1;
          end else begin
            tx_load = mem_data;
            mem_inc = 1'b1;
          end
        end
        CRC1: state_nxt = CRC2;
        CRC2: begin
          state_nxt = RX_CMD;
          sec_inc   = 1'b1;
        end
        default: state_nxt = RX_CMD;
      endcase
    end
  end

  // The memory address is set when the token loads. Each data byte uses
  // it long after that, so a 1-clk read latency is always covered.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_address  <= 24'd0;
      sector_count <= 8'd0;
      gap_cnt      <= 8'd0;
      byte_idx     <= 9'd0;
    end else begin
      if (mem_set)
        mem_address <= base_q;
      else if (mem_inc)
        mem_address <= {mem_address[23:9], mem_address[8:0] + 9'd1};
      if (sec_inc)
        sector_count <= sector_count + 8'd1;
      if (byte_done) begin
        case (state)
          R1:    gap_cnt  <= 8'd0;
          GAP:   gap_cnt  <= gap_cnt + 8'd1;
          TOKEN: byte_idx <= 9'd0;
          DATA:  byte_idx <= byte_idx + 9'd1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_card_responder.sv
// Directed bench for sd_card_responder: an SPI mode-0 host model drives
// frames. Expected MISO bytes go through a scoreboard queue.
module tb_sd_card_responder;

  localparam int HALF = 5;                        // SCLK half period in clk
  localparam logic [23:0] SECTOR_BASE = 24'h010200;

  logic        clk = 1'b0;
  logic        reset;
  logic        spi_cs, spi_clk, spi_di;
  logic        spi_do;
  logic [23:0] mem_address;
  logic [7:0]  mem_data;
  logic        initialized;
  logic [7:0]  sector_count;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  sd_card_responder #(.INIT_POLLS(2), .DATA_GAP(1)) dut (
    .clk(clk), .reset(reset), .spi_cs(spi_cs), .spi_clk(spi_clk),
    .spi_di(spi_di), .spi_do(spi_do), .mem_address(mem_address),
    .mem_data(mem_data), .initialized(initialized),
    .sector_count(sector_count)
  );

  always #5 clk = ~clk;

  // Sector memory: one clk read latency, data = addr[7:0] ^ addr[15:8].
  always_ff @(posedge clk) mem_data <= mem_address[7:0] ^ mem_address[15:8];

  function automatic logic [7:0] exp_data(input int i);
    logic [23:0] a;
    a = SECTOR_BASE + 24'(i);
    return a[7:0] ^ a[15:8];
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full byte; the expected MISO byte is queued before clocking.
  task automatic xfer(input logic [7:0] tx, input logic [7:0] exp, input string tag);
    logic [7:0] rx;
    logic [7:0] e;
    exp_q.push_back(exp);
    for (int i = 7; i >= 0; i--) begin
      spi_di = tx[i];
      wait_clk(HALF);
      spi_clk = 1'b1;
      rx[i] = spi_do;
      wait_clk(HALF);
      spi_clk = 1'b0;
    end
    e = exp_q.pop_front();
    chk(32'(rx), 32'(e), tag);
  endtask

  task automatic send_cmd(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
                          input logic [7:0] r1, input string tag);
    xfer(b0, 8'hff, "frame");
    xfer(b1, 8'hff, "frame");
    xfer(b2, 8'hff, "frame");
    xfer(b3, 8'hff, "frame");
    xfer(b4, 8'hff, "frame");
    xfer(b5, 8'hff, "frame");
    xfer(8'hff, 8'hff, "ncr");
    xfer(8'hff, r1, tag);
  endtask

  initial begin
    reset = 1'b1; spi_cs = 1'b1; spi_clk = 1'b0; spi_di = 1'b1;
    wait_clk(4);
    chk(32'(spi_do), 32'd1, "reset_do");
    chk(32'(mem_address), 32'd0, "reset_addr");
    chk(32'(initialized), 32'd0, "reset_init");
    chk(32'(sector_count), 32'd0, "reset_count");
    reset = 1'b0;
    wait_clk(2);
    spi_cs = 1'b0;
    wait_clk(4);

    // Idle clocks: card answers all-ones.
    for (int i = 0; i < 10; i++) xfer(8'hff, 8'hff, "idle_ff");
    chk(32'(initialized), 32'd0, "idle_init");

    // Before initialization: CMD8 and CMD17 both answer 0x05, and no token.
    send_cmd(8'h48, 8'h00, 8'h00, 8'h01, 8'haa, 8'h87, 8'h05, "r1_cmd8_pre");
    send_cmd(8'h51, 8'h00, 8'h01, 8'h02, 8'h00, 8'hff, 8'h05, "r1_cmd17_pre");
    for (int i = 0; i < 4; i++) xfer(8'hff, 8'hff, "no_token");

    // CMD0 then three CMD1 polls.
    send_cmd(8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95, 8'h01, "r1_cmd0");
    chk(32'(initialized), 32'd0, "init_after_cmd0");
    send_cmd(8'h41, 8'h00, 8'h00, 8'h00, 8'h00, 8'hff, 8'h01, "r1_cmd1_a");
    send_cmd(8'h41, 8'h00, 8'h00, 8'h00, 8'h00, 8'hff, 8'h01, "r1_cmd1_b");
    chk(32'(initialized), 32'd0, "init_after_poll2");
    send_cmd(8'h41, 8'h00, 8'h00, 8'h00, 8'h00, 8'hff, 8'h00, "r1_cmd1_c");
    chk(32'(initialized), 32'd1, "init_after_poll3");

    send_cmd(8'h48, 8'h00, 8'h00, 8'h01, 8'haa, 8'h87, 8'h04, "r1_cmd8_post");

    // Full sector read.
    send_cmd(8'h51, 8'h00, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00, "r1_cmd17");
    xfer(8'hff, 8'hff, "gap");
    xfer(8'hff, 8'hfe, "token");
    for (int i = 0; i < 512; i++) xfer(8'hff, exp_data(i), "data");
    xfer(8'hff, 8'hff, "crc1");
    xfer(8'hff, 8'hff, "crc2");
    wait_clk(4);
    chk(32'(sector_count), 32'd1, "count_after_read");
    xfer(8'hff, 8'hff, "post_read_ff");

    // Aborted read: CS rises in the middle of data byte 100.
    send_cmd(8'h51, 8'h00, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00, "r1_cmd17_abort");
    xfer(8'hff, 8'hff, "gap2");
    xfer(8'hff, 8'hfe, "token2");
    for (int i = 0; i < 100; i++) xfer(8'hff, exp_data(i), "data2");
    for (int i = 7; i >= 5; i--) begin
      spi_di = 1'b1;
      wait_clk(HALF);
      spi_clk = 1'b1;
      wait_clk(HALF);
      spi_clk = 1'b0;
    end
    wait_clk(HALF);
    begin
      logic [7:0] d;
      d = exp_data(100);
      chk(32'(spi_do), 32'(d[4]), "mid_byte_do");
    end
    spi_cs = 1'b1;
    wait_clk(4);
    chk(32'(spi_do), 32'd1, "cs_rise_do");
    wait_clk(4);
    chk(32'(sector_count), 32'd1, "count_after_abort");
    spi_cs = 1'b0;
    wait_clk(4);

    // Repeat read restarts at byte 0 of the sector.
    send_cmd(8'h51, 8'h00, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00, "r1_cmd17_again");
    xfer(8'hff, 8'hff, "gap3");
    xfer(8'hff, 8'hfe, "token3");
    for (int i = 0; i < 4; i++) xfer(8'hff, exp_data(i), "data3");
    spi_cs = 1'b1;
    wait_clk(8);
    chk(32'(spi_do), 32'd1, "cs_rise_do2");
    chk(32'(sector_count), 32'd1, "count_final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
